// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and framing checks.
//
// A frame is one start bit (low), DWIDTH data bits LSB first, an optional parity
// bit and one stop bit (high). The serial line is first passed through a two-flop
// synchronizer; every decision below is taken on the synchronized value rx_s.
// Each bit lasts PRESCALE clock cycles and is sampled near its middle.
//
// Parameters:
//   DWIDTH   - data bits per frame
//   PRESCALE - clock cycles per bit-time (even, >= 8)
//
// Ports:
//   CLK        - clock, all state changes on the rising edge
//   RST        - synchronous, active-low reset
//   RX_IN      - asynchronous serial input, idles high
//   PAR_EN     - 1: a parity bit follows the data bits (latched at frame start)
//   PAR_TYP    - 0: even parity, 1: odd parity (latched at frame start)
//   P_DATA     - last received data word, held between frames
//   DATA_VALID - one-cycle pulse for a frame with no parity or stop error
//   PAR_ERR    - one-cycle pulse when the parity bit is wrong
//   STP_ERR    - one-cycle pulse when the stop bit is sampled low
//   BUSY       - high whenever a frame is being received
//
// Build option:
//   UART_RX_MAJORITY_EN - when defined, each bit is the 2-of-3 majority of rx_s at
//   edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, and bit decisions move
//   to PRESCALE/2+1 (one extra cycle of latency). Otherwise a single sample at
//   PRESCALE/2 is used.

module uart_rx #(
  parameter int unsigned DWIDTH   = 6,
  parameter int unsigned PRESCALE = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DWIDTH-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              BUSY
);

  localparam int unsigned EcW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BcW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [EcW-1:0] EcLast = EcW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
  // The third majority sample arrives one cycle after the nominal centre.
  localparam logic [EcW-1:0] EcDecide = EcW'(PRESCALE / 2 + 1);
`else
  localparam logic [EcW-1:0] EcDecide = EcW'(PRESCALE / 2);
`endif
  localparam logic [BcW-1:0] BcLast = BcW'(DWIDTH - 1);

  if ((PRESCALE < 8) || ((PRESCALE % 2) != 0)) begin : gen_bad_prescale
    $error("uart_rx: PRESCALE must be even and at least 8");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Synchronizer
  logic rx_meta_q;
  logic rx_s_q;

  // Receiver state
  state_e            state_q, state_d;
  logic [EcW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BcW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_fail_q, par_fail_d;

  // Registered outputs
  logic [DWIDTH-1:0] p_data_q, p_data_d;
  logic              data_valid_q, data_valid_d;
  logic              par_err_q, par_err_d;
  logic              stp_err_q, stp_err_d;

  logic bit_tick;
  logic bit_wrap;
  logic bit_val;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Last two values of rx_s; at the decide point these hold the samples from
  // PRESCALE/2-1 and PRESCALE/2, and rx_s itself is the PRESCALE/2+1 sample.
  logic [1:0] samp_q, samp_d;

  always_comb begin
    samp_d = {samp_q[0], rx_s_q};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      samp_q <= 2'b11;
    end else begin
      samp_q <= samp_d;
    end
  end

  always_comb begin
    bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);
  end
`else
  always_comb begin
    bit_val = rx_s_q;
  end
`endif

  always_comb begin
    bit_tick = (edge_cnt_q == EcDecide);
    bit_wrap = (edge_cnt_q == EcLast);
  end

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_fail_d   = par_fail_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != StIdle) begin
      edge_cnt_d = bit_wrap ? '0 : edge_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s_q) begin
          // Frame options are frozen here so mid-frame changes cannot corrupt it.
          state_d    = StStart;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
        end
      end

      StStart: begin
        if (bit_tick && bit_val) begin
          // Line went back high before mid-bit: treat as noise.
          state_d    = StIdle;
          edge_cnt_d = '0;
        end else if (bit_wrap) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end

      StData: begin
        if (bit_tick) begin
          shift_d             = shift_q >> 1;
          shift_d[DWIDTH-1]   = bit_val;
        end
        if (bit_wrap) begin
          if (bit_cnt_q == BcLast) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      StParity: begin
        if (bit_tick) begin
          par_fail_d = (bit_val != ((^shift_q) ^ par_typ_q));
        end
        if (bit_wrap) begin
          state_d = StStop;
        end
      end

      StStop: begin
        // Leave right after the stop sample so a back-to-back start edge, or a
        // slightly fast transmitter, is not missed.
        if (bit_tick) begin
          p_data_d     = shift_q;
          data_valid_d = !par_fail_q && bit_val;
          par_err_d    = par_fail_q;
          stp_err_d    = !bit_val;
          state_d      = StIdle;
          edge_cnt_d   = '0;
        end
      end

      default: begin
        state_d    = StIdle;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_fail_q   <= par_fail_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx (DWIDTH=6, PRESCALE=8).

module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int Maj = 1;
`else
  localparam int Maj = 0;
`endif

  logic          clk;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          BUSY;

  uart_rx #(
    .DWIDTH  (DW),
    .PRESCALE(P)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .BUSY      (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Cycle counter and output monitor; only these blocks write these variables.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_dv = 0;
  int n_pe = 0;
  int n_se = 0;
  int n_busy = 0;
  int last_pulse_cyc = -1000;
  logic [DW-1:0] dv_log[$];

  always @(negedge clk) begin
    if (DATA_VALID) begin
      n_dv++;
      dv_log.push_back(P_DATA);
      last_pulse_cyc = cyc;
    end
    if (PAR_ERR) begin
      n_pe++;
      last_pulse_cyc = cyc;
    end
    if (STP_ERR) begin
      n_se++;
      last_pulse_cyc = cyc;
    end
    if (BUSY) n_busy++;
  end

  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; caller is #1 after a rising edge. glitch_pos inverts the
  // line for one cycle at that offset; flip_pos toggles PAR_EN/PAR_TYP there.
  task automatic send_frame(input logic [DW-1:0] data, input logic with_par,
                            input logic par_bit, input logic stop_bit,
                            input int glitch_pos, input int flip_pos);
    logic [9:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = data[i];
    nb = 1 + DW;
    if (with_par) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    start_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < P; c++) begin
        int pos;
        pos = b * P + c;
        RX_IN = (pos == glitch_pos) ? ~bits[b] : bits[b];
        if (pos == flip_pos) begin
          PAR_EN  = ~PAR_EN;
          PAR_TYP = ~PAR_TYP;
        end
        @(posedge clk);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          pen;
    logic          ptyp;
    logic          pbit;
    logic          stop;
    int            glitch;
    int            flip;
    logic          dv;
    logic          pe;
    logic          se;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int b_dv, b_pe, b_se, b_busy, b_log, lat;
    logic [DW-1:0] exp_pd;

    //          data   pen   ptyp  pbit  stop  glitch flip  dv    pe    se
    vecs[0]  = '{6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, -1,    -1,   1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'h15, 1'b1, 1'b0, 1'b0, 1'b1, -1,    -1,   1'b0, 1'b1, 1'b0};
    vecs[2]  = '{6'h15, 1'b1, 1'b0, 1'b1, 1'b1, -1,    -1,   1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'h15, 1'b1, 1'b1, 1'b0, 1'b1, -1,    -1,   1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'h2A, 1'b1, 1'b1, 1'b1, 1'b1, -1,    -1,   1'b0, 1'b1, 1'b0};
    vecs[5]  = '{6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, -1,    -1,   1'b0, 1'b0, 1'b1};
    vecs[6]  = '{6'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1,    -1,   1'b1, 1'b0, 1'b0};
    vecs[7]  = '{6'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1,    -1,   1'b0, 1'b0, 1'b1};
    vecs[8]  = '{6'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1,    -1,   1'b0, 1'b1, 1'b1};
    vecs[9]  = '{6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 11,    -1,   1'b1, 1'b0, 1'b0};
    vecs[10] = '{6'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1,    20,   1'b1, 1'b0, 1'b0};

    RST = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_p_data", P_DATA, 0);
    check("reset_data_valid", DATA_VALID, 0);
    check("reset_par_err", PAR_ERR, 0);
    check("reset_stp_err", STP_ERR, 0);
    check("reset_busy", BUSY, 0);
    @(posedge clk);
    #1;
    RST = 1'b1;
    idle(4);

    for (int i = 0; i < 11; i++) begin
      PAR_EN  = vecs[i].pen;
      PAR_TYP = vecs[i].ptyp;
      idle(1);
      b_dv = n_dv;
      b_pe = n_pe;
      b_se = n_se;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop, vecs[i].glitch,
                 vecs[i].flip);
      idle(3 * P);
      lat = 3 + P * (1 + DW + (vecs[i].pen ? 1 : 0)) + P / 2 + 1 + Maj;
      check($sformatf("vec%0d_data_valid_count", i), n_dv - b_dv, {31'd0, vecs[i].dv});
      check($sformatf("vec%0d_par_err_count", i), n_pe - b_pe, {31'd0, vecs[i].pe});
      check($sformatf("vec%0d_stp_err_count", i), n_se - b_se, {31'd0, vecs[i].se});
      check($sformatf("vec%0d_p_data", i), P_DATA, vecs[i].data);
      check($sformatf("vec%0d_latency", i), last_pulse_cyc - start_cyc, lat);
    end

    // Short low glitch: false start, no pulses, P_DATA held.
    b_dv = n_dv;
    b_pe = n_pe;
    b_se = n_se;
    b_busy = n_busy;
    RX_IN = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    idle(20);
    check("glitch_busy_cycles", n_busy - b_busy, 5 + Maj);
    check("glitch_busy_after", BUSY, 0);
    check("glitch_no_valid", n_dv - b_dv, 0);
    check("glitch_no_par_err", n_pe - b_pe, 0);
    check("glitch_no_stp_err", n_se - b_se, 0);
    check("glitch_p_data_held", P_DATA, 6'h3C);

    // Back-to-back frames with no idle gap.
    PAR_EN = 1'b0;
    b_dv = n_dv;
    b_log = dv_log.size();
    send_frame(6'h0A, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(6'h35, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(3 * P);
    check("b2b_valid_count", n_dv - b_dv, 2);
    check("b2b_first_data", (dv_log.size() > b_log) ? dv_log[b_log] : 'x, 6'h0A);
    check("b2b_second_data", (dv_log.size() > b_log + 1) ? dv_log[b_log+1] : 'x, 6'h35);

    // One-cycle inversion exactly at the centre of data bit 0.
`ifdef UART_RX_MAJORITY_EN
    exp_pd = 6'h2A;
`else
    exp_pd = 6'h2B;
`endif
    b_dv = n_dv;
    send_frame(6'h2A, 1'b0, 1'b0, 1'b1, P + P / 2 + 1, -1);
    idle(3 * P);
    check("centre_glitch_valid", n_dv - b_dv, 1);
    check("centre_glitch_p_data", P_DATA, exp_pd);

    // Reset in the middle of the data bits, then a clean frame.
    b_dv = n_dv;
    b_pe = n_pe;
    b_se = n_se;
    RX_IN = 1'b0;
    repeat (P) begin
      @(posedge clk);
      #1;
    end
    RX_IN = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("midframe_busy", BUSY, 1);
    RST = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_p_data", P_DATA, 0);
    check("midreset_data_valid", DATA_VALID, 0);
    check("midreset_par_err", PAR_ERR, 0);
    check("midreset_stp_err", STP_ERR, 0);
    check("midreset_busy", BUSY, 0);
    @(posedge clk);
    #1;
    RST = 1'b1;
    idle(4);
    send_frame(6'h2C, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(3 * P);
    check("after_reset_valid_count", n_dv - b_dv, 1);
    check("after_reset_par_err", n_pe - b_pe, 0);
    check("after_reset_stp_err", n_se - b_se, 0);
    check("after_reset_p_data", P_DATA, 6'h2C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DWIDTH, default 6: number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE, default 8: clock cycles per bit-time; legal values are even and >= 8.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port RX_IN, input, 1 bit: serial line; idles high; frames arrive LSB first.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 means a parity bit follows the data bits.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 SHALL have port P_DATA, output, DWIDTH bits: last received data word.
REQ-009 SHALL have port DATA_VALID, output, 1 bit: one-cycle pulse when a frame is received without error.
REQ-010 SHALL have port PAR_ERR, output, 1 bit: one-cycle pulse when the parity check fails.
REQ-011 SHALL have port STP_ERR, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass RX_IN through a 2-flop synchronizer (reset value 1); all logic below uses the synchronized value, rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL implement edge_cnt, 0..PRESCALE-1: cleared on the IDLE->START transition, incremented every cycle outside IDLE, wrapping to 0 at the end of each bit-time.
REQ-016 SHALL define the sample point as edge_cnt == PRESCALE/2; bit value = rx_s at that cycle (see REQ-026 for majority mode).
REQ-017 In IDLE, rx_s == 0 SHALL cause a move to START on the next edge and SHALL latch PAR_EN and PAR_TYP for the whole frame; later changes to either input SHALL NOT affect the frame in progress.
REQ-018 In START, a sampled 1 (false start) SHALL return the FSM to IDLE with no outputs pulsed; a sampled 0 SHALL cause a move to DATA at the bit-time wrap.
REQ-019 In DATA, the block SHALL shift DWIDTH bits LSB first, tracked by bit_cnt 0..DWIDTH-1. After the last bit it SHALL move to PARITY if parity is latched enabled, otherwise to STOP.
REQ-020 In PARITY, error SHALL be flagged when the sampled bit differs from XOR(data) XOR latched PAR_TYP.
REQ-021 In STOP, the FSM SHALL return to IDLE in the cycle after the sample point, without waiting for the bit-time to finish, to tolerate back-to-back frames and clock drift.
REQ-022 At the stop sample point the outputs SHALL be registered so they appear one cycle later:
- P_DATA loads the shifted word.
- DATA_VALID = no parity error AND no stop error.
- PAR_ERR and STP_ERR pulse independently; both may pulse together.
REQ-023 P_DATA SHALL hold its value between frames; it SHALL be updated even on errored frames.
REQ-024 Latency SHALL be: DATA_VALID high 3 cycles after the cycle in which RX_IN is at its stop-bit sample point (2 synchronizer cycles plus 1 register cycle).

Reset
REQ-025 When RST is low at a clock edge, the block SHALL return to IDLE on that edge and discard any partial frame. Reset values:
- P_DATA = 0
- DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0, BUSY = 0
- edge_cnt = 0, bit_cnt = 0
- synchronizer flops = 1

Configuration
REQ-026 With macro UART_RX_MAJORITY_EN defined:
- Each bit value SHALL be the 2-of-3 majority of rx_s at edge_cnt PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
- Decisions that depend on a bit SHALL be taken at PRESCALE/2+1, which adds 1 cycle to the REQ-024 latency.
REQ-027 Without UART_RX_MAJORITY_EN, the single sample at PRESCALE/2 SHALL be used.

Verification
REQ-028 Frame with PAR_EN=0, data 6'h2A, valid stop bit -> exactly one DATA_VALID pulse, P_DATA=6'h2A, PAR_ERR=0, STP_ERR=0.
REQ-029 Frame with PAR_EN=1, PAR_TYP=0, data 6'h15, parity bit 0 (wrong; correct value is 1) -> PAR_ERR pulse, DATA_VALID stays 0, P_DATA=6'h15.
REQ-030 Frame with data 6'h3F and stop bit 0 -> STP_ERR pulse, no DATA_VALID; a following correct frame with data 6'h01 is then received normally.
REQ-031 RX_IN low for 2 cycles then high (glitch) -> BUSY pulses briefly, FSM returns to IDLE, and no output pulse occurs.
REQ-032 Two back-to-back frames, 6'h0A then 6'h35, with no idle gap -> two DATA_VALID pulses with P_DATA values in that order.
REQ-033 RST low mid-DATA, then a clean frame with data 6'h2C -> outputs at reset values during reset, then exactly one DATA_VALID with P_DATA=6'h2C.
REQ-034 With UART_RX_MAJORITY_EN defined: a 1-cycle inverted glitch at PRESCALE/2 on data bit 0 of 6'h2A -> P_DATA=6'h2A, DATA_VALID pulses.
